// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_arbiter
// Description : Two-master arbiter for a single-port on-chip RAM. Round-robin
//               with per-owner hold limit; optional fixed priority via the
//               ONCHIP_ARB_FIXED_PRI_EN macro (m0 always wins).
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_arbiter #(
    parameter int HOLD = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    // master 0
    input  logic [12:0] m0_address,
    input  logic [3:0]  m0_byteenable,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    output logic        m0_waitrequest,
    output logic        m0_readdatavalid,
    output logic [31:0] m0_readdata,
    // master 1
    input  logic [12:0] m1_address,
    input  logic [3:0]  m1_byteenable,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    output logic        m1_waitrequest,
    output logic        m1_readdatavalid,
    output logic [31:0] m1_readdata,
    // memory side
    output logic [12:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic        mem_clken,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] hcnt_q, hcnt_d;
    logic       rr_q, rr_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_id_q, rd_id_d;

    logic req0, req1;
    logic arb0, arb1;
    logic gnt0, gnt1;
    logic same_owner;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Raw arbitration decision; qualified by reset below.
    always_comb begin
        arb0 = 1'b0;
        arb1 = 1'b0;
`ifdef ONCHIP_ARB_FIXED_PRI_EN
        arb0 = req0;
        arb1 = req1 & ~req0;
`else
        case (state_q)
            OWN0: begin
                if (req0) begin
                    if (req1 && (hcnt_q == HOLD_MAX)) arb1 = 1'b1;
                    else                              arb0 = 1'b1;
                end else begin
                    arb1 = req1;
                end
            end
            OWN1: begin
                if (req1) begin
                    if (req0 && (hcnt_q == HOLD_MAX)) arb0 = 1'b1;
                    else                              arb1 = 1'b1;
                end else begin
                    arb0 = req0;
                end
            end
            default: begin
                if (req0 && req1) begin
                    arb0 = rr_q;
                    arb1 = ~rr_q;
                end else begin
                    arb0 = req0;
                    arb1 = req1;
                end
            end
        endcase
`endif
    end

    // Nothing may be accepted while reset is held, including the edge it asserts.
    assign gnt0 = arb0 & reset_n;
    assign gnt1 = arb1 & reset_n;

    assign same_owner = (gnt0 && (state_q == OWN0)) || (gnt1 && (state_q == OWN1));

    always_comb begin
        state_d   = IDLE;
        hcnt_d    = 4'd0;
        rr_d      = rr_q;
        rd_pend_d = 1'b0;
        rd_id_d   = rd_id_q;
        if (gnt0) begin
            state_d = OWN0;
            rr_d    = 1'b0;
        end else if (gnt1) begin
            state_d = OWN1;
            rr_d    = 1'b1;
        end
        if (same_owner) begin
            hcnt_d = (hcnt_q == HOLD_MAX) ? HOLD_MAX : hcnt_q + 4'd1;
        end
        if ((gnt0 && m0_read && !m0_write) || (gnt1 && m1_read && !m1_write)) begin
            rd_pend_d = 1'b1;
            rd_id_d   = gnt1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            hcnt_q    <= 4'd0;
            rr_q      <= 1'b1;
            rd_pend_q <= 1'b0;
            rd_id_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            rr_q      <= rr_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    always_comb begin
        mem_address    = 13'd0;
        mem_byteenable = 4'd0;
        mem_writedata  = 32'd0;
        if (gnt0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
        end else if (gnt1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end
    end

    assign mem_chipselect   = gnt0 | gnt1;
    assign mem_write        = (gnt0 & m0_write) | (gnt1 & m1_write);
    assign mem_clken        = 1'b1;

    assign m0_waitrequest   = req0 & ~gnt0;
    assign m1_waitrequest   = req1 & ~gnt1;
    assign m0_readdatavalid = rd_pend_q & ~rd_id_q;
    assign m1_readdatavalid = rd_pend_q & rd_id_q;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule
`default_nettype wire

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter HOLD, default 4: maximum number of consecutive accepted accesses for one master while the other master is requesting; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports m0_address / m1_address, input, 13 bits: master word address.
REQ-005 SHALL have ports m0_byteenable / m1_byteenable, input, 4 bits: write byte lanes.
REQ-006 SHALL have ports m0_read / m1_read and m0_write / m1_write, input, 1 bit each: access requests.
REQ-007 SHALL have ports m0_writedata / m1_writedata, input, 32 bits: write data.
REQ-008 SHALL have ports m0_waitrequest / m1_waitrequest, output, 1 bit each: request not accepted this cycle.
REQ-009 SHALL have ports m0_readdatavalid / m1_readdatavalid, output, 1 bit each: readdata valid for that master.
REQ-010 SHALL have ports m0_readdata / m1_readdata, output, 32 bits each: both driven from mem_readdata.
REQ-011 SHALL have memory-side outputs mem_address (13 bits), mem_byteenable (4), mem_chipselect (1), mem_write (1), mem_writedata (32), mem_clken (1).
REQ-012 SHALL have port mem_readdata, input, 32 bits: memory q, valid one cycle after the read address is presented.

Function
REQ-013 SHALL define request reqN = mN_read | mN_write; when both are asserted, the access is a write and the read is ignored.
REQ-014 SHALL implement a state machine with states IDLE, OWN0, and OWN1, plus a hold counter hcnt (4 bits) and a round-robin pointer rr (the last master served).
REQ-015 SHALL compute the grant combinationally in the same cycle: IDLE grants the sole requester; on a tie in IDLE, it grants the master other than rr.
REQ-016 In OWNn, SHALL grant n while reqn is high, unless the other master is requesting and hcnt = HOLD-1; in that case it grants the other master.
REQ-017 In OWNn with reqn low, SHALL grant the other master if it is requesting; otherwise no grant.
REQ-018 SHALL set next state to OWNg when master g is granted, and to IDLE when there is no grant.
REQ-019 SHALL increment hcnt on a grant to the same owner and clear it to 0 on an owner change or IDLE; hcnt SHALL saturate at HOLD-1.
REQ-020 SHALL update rr to g on every grant.
REQ-021 mN_waitrequest SHALL equal reqN & ~grantN; a granted access is accepted in that cycle.
REQ-022 SHALL drive mem_address, mem_byteenable, and mem_writedata from the granted master (all zero with no grant), and mem_chipselect = any grant.
REQ-023 SHALL assert mem_write = 1 only for a granted write.
REQ-024 SHALL tie mem_clken to 1.
REQ-025 SHALL register a rd_pend valid bit and master id on each accepted read; mN_readdatavalid SHALL be asserted exactly 1 cycle after acceptance, for the issuing master only.
REQ-026 SHALL support back-to-back reads (one per cycle), including alternating masters, with no bubble.
REQ-027 SHALL give writes no readdatavalid response.
REQ-028 A read accepted in the cycle after a write to the same address SHALL return the new data, since memory writes complete at the edge.

Reset
REQ-029 On reset_n low, SHALL asynchronously set: state IDLE, hcnt 0, rr = 1 (so m0 wins the first tie), rd_pend 0, and both readdatavalid outputs 0.
REQ-030 While in reset, SHALL hold mem_chipselect and mem_write at 0 and both waitrequest outputs equal to reqN.
REQ-031 SHALL drop a read accepted in the cycle reset asserts: no readdatavalid after reset release.
REQ-032 SHALL leave the cycle after reset release in IDLE with the normal grant rules.

Configuration
REQ-033 SHALL provide macro ONCHIP_ARB_FIXED_PRI_EN: when defined, m0 always wins any contention, m1 is granted only when m0 is not requesting, and hcnt/rr have no effect.
REQ-034 When ONCHIP_ARB_FIXED_PRI_EN is not defined, SHALL use the round-robin-with-hold behaviour of REQ-015 to REQ-020.

Verification
REQ-035 After reset, m0 and m1 both read in the same cycle -> m0 granted, m1_waitrequest=1; m0_readdatavalid=1 one cycle later with the word at m0's address.
REQ-036 With HOLD=4, m0 and m1 requesting continuously -> grant pattern m0,m0,m0,m0,m1,m1,m1,m1,m0...; never more than 4 in a row.
REQ-037 m0 writes 0xDEADBEEF to address 0x0010 with byteenable 0x3, then m1 reads 0x0010 the next cycle -> m1_readdata = old[31:16] concatenated with 0xBEEF, m0_readdatavalid stays 0.
REQ-038 Alternating single-cycle reads m0@0x1FFF, m1@0x0000 -> readdatavalid alternates every cycle with the correct master and data, and no waitrequest.
REQ-039 reset_n pulsed low in the cycle after an accepted m1 read -> m1_readdatavalid=0 and state IDLE; the next tie grants m0.
REQ-040 Build with ONCHIP_ARB_FIXED_PRI_EN and m0 requesting continuously -> m1_waitrequest stays 1 for all cycles until m0 deasserts, then m1 is granted the same cycle.
